// File: rtl/cla_seq_add_ctrl.sv
// Sequential carry-lookahead adder: one SLICE-bit CLA add per cycle, LSB slice first.
// Optional subtract mode is enabled by defining CLA_SEQ_SUB_EN.
module cla_seq_add_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int NG = SLICE / 4;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic [IW-1:0]    idx_q;
  logic             c_q, cout_q, ovf_q;

  logic [WIDTH-1:0] b_in;
  logic             c_in;

  logic [SLICE-1:0] sa, sb, sp, sg, sc, ss;
  logic [NG-1:0]    gp, gg;
  logic [NG:0]      gc;
  logic             cy, tm;

  // Carries into bits 0..3 of one group, two-level AND-OR, no ripple.
  function automatic logic [3:0] cla4(
    input logic [3:0] g,
    input logic [3:0] p,
    input logic       ci
  );
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0])
         | (&p[2:0] & ci);
    return c;
  endfunction

  // Operand conditioning at latch time (subtract inverts b, forces carry).
  always_comb begin
    b_in = b;
    c_in = cin;
`ifdef CLA_SEQ_SUB_EN
    if (sub) begin
      b_in = ~b;
      c_in = 1'b1;
    end
`endif
  end

  // Slice select, group P/G, second-level lookahead and slice sum.
  always_comb begin
    sa    = '0;
    sb    = '0;
    sum_d = sum_q;
    gp    = '0;
    gg    = '0;
    gc    = '0;
    sc    = '0;
    cy    = 1'b0;
    tm    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        sa = a_q[i*SLICE +: SLICE];
        sb = b_q[i*SLICE +: SLICE];
      end
    end
    sp = sa ^ sb;
    sg = sa & sb;
    for (int k = 0; k < NG; k++) begin
      gp[k] = &sp[4*k +: 4];
      gg[k] = sg[4*k+3]
            | (sp[4*k+3] & sg[4*k+2])
            | (&sp[4*k+2 +: 2] & sg[4*k+1])
            | (&sp[4*k+1 +: 3] & sg[4*k]);
    end
    for (int k = 0; k <= NG; k++) begin
      cy = c_q;
      for (int j = 0; j < k; j++) cy = cy & gp[j];
      for (int j = 0; j < k; j++) begin
        tm = gg[j];
        for (int m = j + 1; m < k; m++) tm = tm & gp[m];
        cy = cy | tm;
      end
      gc[k] = cy;
    end
    for (int k = 0; k < NG; k++) begin
      sc[4*k +: 4] = cla4(sg[4*k +: 4], sp[4*k +: 4], gc[k]);
    end
    ss = sp ^ sc;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) sum_d[i*SLICE +: SLICE] = ss;
    end
  end

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand latches, slice counter, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        a_q   <= a;
        b_q   <= b_in;
        c_q   <= c_in;
        idx_q <= '0;
      end
      if (state_q == RUN) begin
        sum_q <= sum_d;
        c_q   <= gc[NG];
        if (idx_q == LAST) begin
          cout_q <= gc[NG];
          ovf_q  <= sc[SLICE-1] ^ gc[NG];
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Directed bench for cla_seq_add_ctrl with a queue scoreboard.
// Subtract cases run when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_add_ctrl;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, cin, sub;
  logic [31:0] a, b;
  logic        ready, busy, done, cout, ovf;
  logic [31:0] sum;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  cla_seq_add_ctrl #(.WIDTH(32), .SLICE(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  function automatic exp_t model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        ci,
    input logic        s
  );
    exp_t        r;
    logic [32:0] t;
    logic [31:0] yy;
    logic        cc;
    yy     = s ? ~y : y;
    cc     = s ? 1'b1 : ci;
    t      = {1'b0, x} + {1'b0, yy} + {32'b0, cc};
    r.sum  = t[31:0];
    r.cout = t[32];
    r.ovf  = (x[31] == yy[31]) && (t[31] != x[31]);
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] ia,
                        input logic [31:0] ib,
                        input logic        ic,
                        input logic        is);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", {63'b0, ready}, 64'd1);
    a     = ia;
    b     = ib;
    cin   = ic;
    sub   = is;
    start = 1'b1;
    sb.push_back(model(ia, ib, ic, is));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    cin   = 1'($urandom);
    sub   = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int   cnt;
    exp_t x;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!done && cnt < 20);
    chk({tag, "_latency"}, 64'(cnt), 64'd5);
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    x = (sb.size() > 0) ? sb.pop_front() : '{32'hx, 1'bx, 1'bx};
    chk({tag, "_sum"}, {32'b0, sum}, {32'b0, x.sum});
    chk({tag, "_cout"}, {63'b0, cout}, {63'b0, x.cout});
    chk({tag, "_ovf"}, {63'b0, ovf}, {63'b0, x.ovf});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
    chk({tag, "_ready_back"}, {63'b0, ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'b0, ready}, 64'd1);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_sum", {32'b0, sum}, 64'd0);
    chk("rst_cout", {63'b0, cout}, 64'd0);
    chk("rst_ovf", {63'b0, ovf}, 64'd0);

    accept(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done("wrap");
    accept(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done("sovf");
    accept(32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0);
    wait_done("cin1");
    accept(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0);
    wait_done("alt");

    // start pulses during RUN and DONE must be ignored
    accept(32'd1, 32'd1, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("ign_ready_low", {63'b0, ready}, 64'd0);
      if (c == 5) begin
        e = sb.pop_front();
        chk("ign_done", {63'b0, done}, 64'd1);
        chk("ign_sum", {32'b0, sum}, {32'b0, e.sum});
      end
      start = 1'b1;
      a     = 32'hFFFF0000;
      b     = 32'h0000FFFF;
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ign_ready_back", {63'b0, ready}, 64'd1);
    chk("ign_sum_hold", {32'b0, sum}, 64'h2);

    // reset in the middle of RUN
    accept(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    void'(sb.pop_front());
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {63'b0, ready}, 64'd1);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_done", {63'b0, done}, 64'd0);
    chk("mid_rst_sum", {32'b0, sum}, 64'd0);
    chk("mid_rst_cout", {63'b0, cout}, 64'd0);
    accept(32'd3, 32'd4, 1'b0, 1'b0);
    wait_done("post_rst");

    // start held high with fresh operands every cycle
    begin
      int n;
      n = 0;
      while (!ready && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int t = 0; t < 18; t++) begin
      if (t > 0) @(negedge clk);
      chk($sformatf("held_ready_t%0d", t), {63'b0, ready},
          {63'b0, (t % 6) == 0});
      if ((t % 6) == 5) begin
        e = (sb.size() > 0) ? sb.pop_front() : '{32'hx, 1'bx, 1'bx};
        chk($sformatf("held_done_t%0d", t), {63'b0, done}, 64'd1);
        chk($sformatf("held_sum_t%0d", t), {32'b0, sum}, {32'b0, e.sum});
        chk($sformatf("held_cout_t%0d", t), {63'b0, cout},
            {63'b0, e.cout});
        chk($sformatf("held_ovf_t%0d", t), {63'b0, ovf}, {63'b0, e.ovf});
      end
      if (t < 17) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        cin   = 1'($urandom);
        sub   = 1'b0;
        if ((t % 6) == 0) sb.push_back(model(a, b, cin, 1'b0));
      end else begin
        start = 1'b0;
      end
    end

`ifdef CLA_SEQ_SUB_EN
    accept(32'd5, 32'd7, 1'b0, 1'b1);
    wait_done("sub_neg");
    accept(32'h80000000, 32'd1, 1'b0, 1'b1);
    wait_done("sub_ovf");
    accept(32'd9, 32'd9, 1'b0, 1'b1);
    wait_done("sub_eq");
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
